// File: rtl/gate_truth_sweep_if.sv
// gate_truth_sweep_if: control, expected-word and result bundle for the gate truth-table sweeper
//   i_start/i_abort  sweep request / cancel
//   i_expected       expected truth table, bit i = gate output for index i
//   i_gate_in        output of the gate under sweep
//   o_a/o_b/o_c      gate inputs, {a,b,c} = current index
//   o_busy/o_done    sweep in progress / one-cycle completion pulse
//   o_pass/o_table_out/o_fail_idx  sweep results
interface gate_truth_sweep_if;
  logic       i_start;
  logic       i_abort;
  logic [7:0] i_expected;
  logic       i_gate_in;
  logic       o_a;
  logic       o_b;
  logic       o_c;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic [7:0] o_table_out;
  logic [2:0] o_fail_idx;
  modport slave (
    input  i_start, i_abort, i_expected, i_gate_in,
    output o_a, o_b, o_c, o_busy, o_done, o_pass, o_table_out, o_fail_idx
  );
  modport master (
    output i_start, i_abort, i_expected, i_gate_in,
    input  o_a, o_b, o_c, o_busy, o_done, o_pass, o_table_out, o_fail_idx
  );
endinterface

// File: rtl/gate_truth_sweep.sv
// gate_truth_sweep: drives a 3-input gate through all 8 vectors, captures and checks its truth table
//   clk, rst  clock and synchronous active-high reset
//   bus       gate_truth_sweep_if.slave (control in, gate drive and results out)
module gate_truth_sweep #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input logic               clk,
  input logic               rst,
  gate_truth_sweep_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  state_t           r_state, w_nxt_state;
  logic [2:0]       r_idx, w_nxt_idx;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [7:0]       r_exp, w_nxt_exp;
  logic [7:0]       r_tab, w_nxt_tab;
  logic             r_pass, w_nxt_pass;
  logic [2:0]       r_fail, w_nxt_fail;
  logic [7:0]       w_tab;
  logic [7:0]       w_diff;
  logic [2:0]       w_fail;
  // table as it will stand once the current sample is taken; results are
  // computed from it so pass/fail_idx are already valid in the DONE cycle
  always_comb begin
    w_tab = r_tab;
    w_tab[r_idx] = bus.i_gate_in;
    w_diff = w_tab ^ r_exp;
    w_fail = 3'd0;
    for (int i = 7; i >= 0; i--) if (w_diff[i]) w_fail = 3'(i);
  end
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx = r_idx;
    w_nxt_cnt = r_cnt;
    w_nxt_exp = r_exp;
    w_nxt_tab = r_tab;
    w_nxt_pass = r_pass;
    w_nxt_fail = r_fail;
    case (r_state)
      IDLE: if (bus.i_start && !bus.i_abort) begin
        w_nxt_state = DRIVE;
        w_nxt_idx = 3'd0;
        w_nxt_cnt = RELOAD;
        w_nxt_exp = bus.i_expected;
        w_nxt_tab = 8'd0;
        w_nxt_pass = 1'b0;
        w_nxt_fail = 3'd0;
      end
      DRIVE: begin
        w_nxt_state = r_cnt == '0 ? SAMPLE : DRIVE;
        w_nxt_cnt = r_cnt == '0 ? r_cnt : r_cnt - 1'b1;
      end
      SAMPLE: begin
        w_nxt_tab = w_tab;
        w_nxt_state = r_idx == 3'd7 ? DONE : DRIVE;
        w_nxt_idx = r_idx == 3'd7 ? r_idx : r_idx + 3'd1;
        w_nxt_cnt = RELOAD;
        w_nxt_pass = r_idx == 3'd7 ? w_diff == 8'd0 : r_pass;
        w_nxt_fail = r_idx == 3'd7 ? w_fail : r_fail;
      end
      default: w_nxt_state = IDLE;
    endcase
    // abort overrides everything in DRIVE/SAMPLE, discarding any pending sample
    if (bus.i_abort && (r_state == DRIVE || r_state == SAMPLE)) begin
      w_nxt_state = IDLE;
      w_nxt_idx = 3'd0;
      w_nxt_cnt = r_cnt;
      w_nxt_tab = 8'd0;
      w_nxt_pass = 1'b0;
      w_nxt_fail = 3'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= 3'd0;
      r_cnt <= '0;
      r_exp <= 8'd0;
      r_tab <= 8'd0;
      r_pass <= 1'b0;
      r_fail <= 3'd0;
    end else begin
      r_state <= w_nxt_state;
      r_idx <= w_nxt_idx;
      r_cnt <= w_nxt_cnt;
      r_exp <= w_nxt_exp;
      r_tab <= w_nxt_tab;
      r_pass <= w_nxt_pass;
      r_fail <= w_nxt_fail;
    end
  end
  assign {bus.o_a, bus.o_b, bus.o_c} = r_idx;
  assign bus.o_busy = r_state == DRIVE || r_state == SAMPLE;
  assign bus.o_done = r_state == DONE;
  assign bus.o_pass = r_pass;
  assign bus.o_table_out = r_tab;
  assign bus.o_fail_idx = r_fail;
endmodule

// File: doc/gate_truth_sweep.md
Name: gate_truth_sweep

Overview:
- Sequential stimulus-and-capture stage that sits directly upstream and downstream of a 3-input logic gate (OR3, KATIO_NOR3 or any a/b/c -> 1-bit gate).
- Drives a, b, c through all 8 input combinations in fixed order and samples the gate output after a programmable settle time.
- Assembles an 8-bit truth table and compares it against an expected word.
- Reports pass/fail and the lowest failing index. Used for in-design self-check of ALU gate cells.

Parameters:
- SETTLE_CYCLES, 1, cycles each vector is held before the sample cycle; legal range 1..15.
- CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE.
- abort  input  1  cancel a sweep in progress.
- expected  input  8  expected truth table; bit i = gate output for index i; latched when start is accepted.
- gate_in  input  1  output of the gate under sweep.
- a  output  1  gate input, index bit 2 (MSB).
- b  output  1  gate input, index bit 1.
- c  output  1  gate input, index bit 0 (LSB).
- busy  output  1  high in DRIVE and SAMPLE.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  table_out == latched expected; valid from the done cycle.
- table_out  output  8  captured truth table; bit i = gate_in sampled for index i.
- fail_idx  output  3  lowest i where table_out[i] != expected[i]; 0 when pass=1.

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-sweep):
  - state=IDLE, idx=0.
  - a=b=c=0, busy=0, done=0, pass=0, table_out=0, fail_idx=0, settle counter=0, latched expected=0.
- Vector order: idx 0..7 ascending. {a,b,c} = idx, so the sequence is 000, 001, 010, ..., 111. a, b, c are registered outputs.
- IDLE:
  - start=1 and abort=0 -> DRIVE at the next edge.
  - On that edge: idx=0, {a,b,c}=000, counter=SETTLE_CYCLES-1, latch expected, table_out=0, pass=0, fail_idx=0.
  - start=1 and abort=1 together -> stay in IDLE; abort wins.
- DRIVE:
  - Lasts exactly SETTLE_CYCLES cycles; counter decrements each cycle.
  - When counter==0 -> SAMPLE.
- SAMPLE:
  - Lasts 1 cycle. gate_in is captured into table_out[idx] at the edge leaving SAMPLE.
  - If idx<7: idx+1, {a,b,c} updated, counter reloaded, -> DRIVE.
  - If idx==7 -> DONE.
- DONE:
  - One cycle; done=1, busy=0. pass and fail_idx are valid in this cycle, computed from the final table.
  - start is ignored. -> IDLE.
- Holding: table_out, pass and fail_idx hold until the next accepted start or reset. a, b, c hold 111 after completion until the next start.
- Latency:
  - a, b, c stay stable across DRIVE+SAMPLE, i.e. SETTLE_CYCLES+1 cycles per vector.
  - busy is high for 8*(SETTLE_CYCLES+1) cycles; done follows immediately after.
  - Start-to-done = 8*(SETTLE_CYCLES+1)+1 cycles, counted from the accepting edge.
- Abort in DRIVE or SAMPLE:
  - -> IDLE at the next edge; no done pulse.
  - a=b=c=0, table_out=0, pass=0, fail_idx=0. A sample pending on that edge is discarded.
- Abort in IDLE or DONE: no effect; DONE still returns to IDLE with its results.
- start held high continuously: back-to-back sweeps separated by exactly one IDLE cycle after DONE.
- expected changing mid-sweep: no effect; only the latched copy is compared.
- fail_idx: priority encode of (table_out XOR latched expected), lowest set bit wins.

Test Plan:
- SETTLE=1, gate=OR3, expected=8'hFE, start pulse:
  - busy high 16 cycles; a,b,c step 000..111 every 2 cycles.
  - done pulse at cycle 17; table_out=8'hFE, pass=1, fail_idx=0.
- SETTLE=1, gate=KATIO_NOR3, expected=8'h01 -> table_out=8'h01, pass=1, fail_idx=0.
- Gate=OR3, expected=8'hFF -> table_out=8'hFE, pass=0, fail_idx=0.
- Gate=OR3, expected=8'hF6 -> pass=0, fail_idx=3.
- SETTLE=3, gate=OR3:
  - each vector held 4 cycles; busy 32 cycles; done at cycle 33; table_out=8'hFE.
- Robustness and control:
  - abort asserted while idx=4 -> IDLE next edge, no done, a=b=c=0, table_out=0.
  - rst asserted mid-sweep -> all outputs 0 next edge.
  - start+abort together in IDLE -> remains IDLE.
  - start held high -> second sweep begins one cycle after the done pulse.
